time_set_controller: RTL and testbench

//   Timekeeping and set-mode sequencer for the digital clock. Consumes the 1 Hz tick and the
//   500 ms blink level from the clock divisor, plus debounced button pulses. Maintains the
//   HH:MM:SS time-of-day and runs the RUN / SET_HOUR / SET_MIN state machine. Drives the

---
 rtl/clock_pkg.sv | 17 +
 rtl/time_set_controller_mod_counter.sv | 28 ++
 rtl/time_set_controller.sv | 113 +++++++++++
 tb/tb_time_set_controller.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and field widths for the digital clock timekeeping path.
//   mode_e  : RUN / SET_HOUR / SET_MIN state encoding (2'b11 is unused/illegal)
//   *_MOD   : field moduli for seconds and minutes
//   *_W     : binary field widths driven to the display encoder
package clock_pkg;
    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_e;

    localparam int SEC_MOD = 60;
    localparam int MIN_MOD = 60;
    localparam int HOUR_W  = 5;
    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;
endpackage

// File: rtl/time_set_controller_mod_counter.sv
// Modulo-MOD up counter used for each time field.
//   clk, rst_i : clock, async active-high reset (value -> 0)
//   inc_i      : advance by one, wrapping MOD-1 -> 0
//   clr_i      : synchronous clear, has priority over inc_i
//   val_o      : registered count, 0..MOD-1
//   carry_o    : combinational, high when an increment wraps the field
module mod_counter #(
    parameter int MOD = 60,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] val_o,
    output logic         carry_o
);
    logic at_max;

    assign at_max  = (val_o == W'(MOD - 1));
    assign carry_o = inc_i & at_max;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i)      val_o <= '0;
        else if (clr_i) val_o <= '0;
        else if (inc_i) val_o <= at_max ? '0 : val_o + 1'b1;
    end
endmodule

// File: rtl/time_set_controller.sv
// Time-of-day keeper and RUN / SET_HOUR / SET_MIN sequencer.
//   clk, rst_i            : 100 MHz clock, async active-high reset
//   tick_1hz_i            : one-cycle pulse per second
//   blink_i               : 500 ms blink level
//   btn_mode_i, btn_inc_i : debounced one-cycle button pulses
//   hours_o/minutes_o/seconds_o : binary time fields (registered)
//   mode_o                : current mode_e state
//   blank_hours_o/blank_minutes_o : registered blink-driven blanking of the field being set
module time_set_controller
    import clock_pkg::*;
#(
    parameter int TIMEOUT_S = 30,
    parameter int HOURS_MOD = 24
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              tick_1hz_i,
    input  logic              blink_i,
    input  logic              btn_mode_i,
    input  logic              btn_inc_i,
    output logic [HOUR_W-1:0] hours_o,
    output logic [MIN_W-1:0]  minutes_o,
    output logic [SEC_W-1:0]  seconds_o,
    output logic [1:0]        mode_o,
    output logic              blank_hours_o,
    output logic              blank_minutes_o
);
    localparam int TW = $clog2(TIMEOUT_S + 1);

    mode_e         mode, mode_n;
    logic [TW-1:0] tcnt;
    logic          tcnt_inc;
    logic          run_count, sec_clr, set_hr_inc, set_min_inc;
    logic          sec_inc, min_inc, hr_inc;
    logic          sec_carry, min_carry, hr_carry_unused;
    logic          any_btn;

    assign any_btn = btn_mode_i | btn_inc_i;

    // Next-state and field control. The carry chain is kept out of this block
    // (plain assigns below) so the counters' combinational carries don't loop
    // back through a single process.
    always_comb begin
        mode_n      = mode;
        run_count   = 1'b0;
        sec_clr     = 1'b0;
        set_hr_inc  = 1'b0;
        set_min_inc = 1'b0;
        tcnt_inc    = 1'b0;
        case (mode)
            MODE_RUN: begin
                if (btn_mode_i) begin
                    mode_n  = MODE_SET_HOUR;
                    sec_clr = 1'b1;       // a coincident tick is dropped
                end else begin
                    run_count = 1'b1;
                end
            end
            MODE_SET_HOUR: begin
                if (btn_mode_i)     mode_n     = MODE_SET_MIN;
                else if (btn_inc_i) set_hr_inc = 1'b1;
            end
            MODE_SET_MIN: begin
                if (btn_mode_i)     mode_n      = MODE_RUN;
                else if (btn_inc_i) set_min_inc = 1'b1;
            end
            default: mode_n = MODE_RUN;
        endcase

        // Inactivity timeout: only a tick with no button advances it, so a
        // button in the same cycle always wins.
        if ((mode == MODE_SET_HOUR || mode == MODE_SET_MIN) && !any_btn && tick_1hz_i) begin
            if (int'(tcnt) + 1 >= TIMEOUT_S) mode_n   = MODE_RUN;
            else                             tcnt_inc = 1'b1;
        end
    end

    assign sec_inc = run_count & tick_1hz_i;
    assign min_inc = set_min_inc | (run_count & sec_carry);
    assign hr_inc  = set_hr_inc  | (run_count & min_carry);

    mod_counter #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
        .clk(clk), .rst_i(rst_i), .inc_i(sec_inc), .clr_i(sec_clr),
        .val_o(seconds_o), .carry_o(sec_carry)
    );
    mod_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
        .clk(clk), .rst_i(rst_i), .inc_i(min_inc), .clr_i(1'b0),
        .val_o(minutes_o), .carry_o(min_carry)
    );
    mod_counter #(.MOD(HOURS_MOD), .W(HOUR_W)) u_hr (
        .clk(clk), .rst_i(rst_i), .inc_i(hr_inc), .clr_i(1'b0),
        .val_o(hours_o), .carry_o(hr_carry_unused)
    );

    // State, timeout counter and blank flags. Blanks key off the next state so
    // they never lag the mode output and are guaranteed 0 once back in RUN.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            mode            <= MODE_RUN;
            tcnt            <= '0;
            blank_hours_o   <= 1'b0;
            blank_minutes_o <= 1'b0;
        end else begin
            mode <= mode_n;
            if (mode_n != mode || any_btn) tcnt <= '0;
            else if (tcnt_inc)             tcnt <= tcnt + 1'b1;
            blank_hours_o   <= (mode_n == MODE_SET_HOUR) & blink_i;
            blank_minutes_o <= (mode_n == MODE_SET_MIN)  & blink_i;
        end
    end

    assign mode_o = mode;
endmodule

// File: tb/tb_time_set_controller.sv
module tb_time_set_controller;
    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       tick_1hz_i = 1'b0, blink_i = 1'b0, btn_mode_i = 1'b0, btn_inc_i = 1'b0;
    logic [4:0] hours_o;
    logic [5:0] minutes_o, seconds_o;
    logic [1:0] mode_o;
    logic       blank_hours_o, blank_minutes_o;

    logic blink = 1'b0;
    int   tests = 0, fails = 0;

    typedef struct {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [1:0] md;
        logic       bh;
        logic       bm;
        string      name;
    } exp_t;

    exp_t sb[$];

    time_set_controller #(.TIMEOUT_S(30), .HOURS_MOD(24)) dut (
        .clk(clk), .rst_i(rst_i), .tick_1hz_i(tick_1hz_i), .blink_i(blink_i),
        .btn_mode_i(btn_mode_i), .btn_inc_i(btn_inc_i),
        .hours_o(hours_o), .minutes_o(minutes_o), .seconds_o(seconds_o),
        .mode_o(mode_o), .blank_hours_o(blank_hours_o), .blank_minutes_o(blank_minutes_o)
    );

    always #5 clk = ~clk;

    function automatic void check(input exp_t e);
        tests++;
        if (hours_o !== e.h || minutes_o !== e.m || seconds_o !== e.s ||
            mode_o !== e.md || blank_hours_o !== e.bh || blank_minutes_o !== e.bm) begin
            fails++;
            $display("FAIL %s: got %0d:%0d:%0d mode=%0d bh=%0b bm=%0b, expected %0d:%0d:%0d mode=%0d bh=%0b bm=%0b",
                     e.name, hours_o, minutes_o, seconds_o, mode_o, blank_hours_o, blank_minutes_o,
                     e.h, e.m, e.s, e.md, e.bh, e.bm);
        end
    endfunction

    // Monitor: outputs settle after the posedge, so compare every pending
    // expectation on the following falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) check(sb.pop_front());
    end

    task automatic step(input logic t, input logic md, input logic inc);
        @(negedge clk);
        tick_1hz_i = t; btn_mode_i = md; btn_inc_i = inc; blink_i = blink;
        @(posedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic incs(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic expect_out(input int h, input int m, input int s, input int md,
                              input logic bh, input logic bm, input string name);
        exp_t e;
        e.h = 5'(h); e.m = 6'(m); e.s = 6'(s); e.md = 2'(md);
        e.bh = bh; e.bm = bm; e.name = name;
        sb.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t z;
        z.h = '0; z.m = '0; z.s = '0; z.md = '0; z.bh = 1'b0; z.bm = 1'b0;

        // 1: reset, then count in RUN
        repeat (3) @(negedge clk);
        #1; z.name = "reset_state"; check(z);
        @(negedge clk); rst_i = 1'b0;
        ticks(60);  expect_out(0, 1, 0, 0, 0, 0, "run_60_ticks");
        ticks(1);   expect_out(0, 1, 1, 0, 0, 0, "run_61_ticks");

        // 2: preload 23:59:58 via set mode, then wrap the whole day
        step(0, 1, 0); expect_out(0, 1, 0, 1, 0, 0, "enter_set_hour_clr_sec");
        incs(23);      expect_out(23, 1, 0, 1, 0, 0, "set_hour_23");
        step(0, 1, 0); expect_out(23, 1, 0, 2, 0, 0, "enter_set_min");
        incs(58);      expect_out(23, 59, 0, 2, 0, 0, "set_min_59");
        step(0, 1, 0); expect_out(23, 59, 0, 0, 0, 0, "back_to_run");
        ticks(58);     expect_out(23, 59, 58, 0, 0, 0, "run_to_235958");
        ticks(1);      expect_out(23, 59, 59, 0, 0, 0, "run_235959");
        ticks(1);      expect_out(0, 0, 0, 0, 0, 0, "day_wrap");

        // 3: field wrap in set modes, no carry from minutes into hours
        ticks(5);      expect_out(0, 0, 5, 0, 0, 0, "run_5s");
        step(0, 1, 0); expect_out(0, 0, 0, 1, 0, 0, "set_hour_sec0");
        incs(25);      expect_out(1, 0, 0, 1, 0, 0, "hour_wrap_25_incs");
        step(0, 1, 0); expect_out(1, 0, 0, 2, 0, 0, "enter_set_min2");
        incs(61);      expect_out(1, 1, 0, 2, 0, 0, "min_wrap_no_carry");
        step(0, 1, 0); expect_out(1, 1, 0, 0, 0, 0, "back_to_run2");

        // 4: inc ignored in RUN; mode+inc+tick together
        step(0, 0, 1); expect_out(1, 1, 0, 0, 0, 0, "run_ignores_inc");
        ticks(3);      expect_out(1, 1, 3, 0, 0, 0, "run_3s");
        step(1, 1, 1); expect_out(1, 1, 0, 1, 0, 0, "mode_inc_tick_same_cycle");
        step(1, 0, 0); expect_out(1, 1, 0, 1, 0, 0, "set_hour_tick_holds");
        step(0, 1, 0); expect_out(1, 1, 0, 2, 0, 0, "to_set_min3");
        step(0, 1, 0); expect_out(1, 1, 0, 0, 0, 0, "to_run3");
        ticks(1);      expect_out(1, 1, 1, 0, 0, 0, "resume_from_sec0");

        // 5: blanking in SET_MIN and inactivity timeout
        step(0, 1, 0); expect_out(1, 1, 0, 1, 0, 0, "to_set_hour4");
        step(0, 1, 0); expect_out(1, 1, 0, 2, 0, 0, "to_set_min4");
        blink = 1'b1;
        step(0, 0, 0); expect_out(1, 1, 0, 2, 0, 1, "blank_min_on");
        blink = 1'b0;
        step(0, 0, 0); expect_out(1, 1, 0, 2, 0, 0, "blank_min_off");
        blink = 1'b1;
        ticks(29);     expect_out(1, 1, 0, 2, 0, 1, "no_timeout_at_29");
        ticks(1);      expect_out(1, 1, 0, 0, 0, 0, "timeout_to_run");
        blink = 1'b0;

        // 5b: a button restarts the timeout and beats a coincident timeout tick
        step(0, 1, 0); expect_out(1, 1, 0, 1, 0, 0, "to_set_hour5");
        ticks(29);     expect_out(1, 1, 0, 1, 0, 0, "set_hour_29_ticks");
        step(1, 0, 1); expect_out(2, 1, 0, 1, 0, 0, "btn_beats_timeout");
        ticks(29);     expect_out(2, 1, 0, 1, 0, 0, "timeout_restarted");
        ticks(1);      expect_out(2, 1, 0, 0, 0, 0, "timeout_to_run2");

        // 6: async reset mid SET_HOUR
        step(0, 1, 0); expect_out(2, 1, 0, 1, 0, 0, "to_set_hour6");
        blink = 1'b1;
        step(0, 0, 0); expect_out(2, 1, 0, 1, 1, 0, "blank_hour_on");
        @(negedge clk);
        tick_1hz_i = 1'b0; btn_mode_i = 1'b0; btn_inc_i = 1'b0;
        #2 rst_i = 1'b1;
        #1; z.name = "async_reset"; check(z);
        @(negedge clk); rst_i = 1'b0; blink = 1'b0; blink_i = 1'b0;
        ticks(1);      expect_out(0, 0, 1, 0, 0, 0, "tick_after_reset");
        step(0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
